// File: rtl/synthesijer_fmul32_core.sv
// Pipelined IEEE-754 binary32 multiplier (flush-to-zero, round-to-nearest-even).
// Define SYNTHESIJER_FMUL32_OUTREG_EN to add one output register stage (latency 4 instead of 3).
module synthesijer_fmul32_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_b_tvalid,
  output logic [31:0] m_axis_result_tdata,
  output logic        m_axis_result_tvalid
);
  // Handshake: no tready anywhere. An operand pair is taken on any edge where both
  // tvalids are high, and each product leaves as a single-cycle m_axis_result_tvalid pulse.
  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

  function automatic cls_e classify(input logic [31:0] x);
    if (x[30:23] == 8'd0)       return CLS_ZERO;
    else if (x[30:23] == 8'hFF) return (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    else                        return CLS_NUM;
  endfunction

  logic accept;
  assign accept = s_axis_a_tvalid & s_axis_b_tvalid;

  // Stage 1: unpack and classify
  cls_e              cls_a, cls_b, cls1_d, cls1_q;
  logic              sign1_d, sign1_q;
  logic signed [9:0] exp1_d, exp1_q;
  logic [23:0]       mant_a1_q, mant_b1_q;
  logic              v1_q;

  always_comb begin
    cls_a   = classify(s_axis_a_tdata);
    cls_b   = classify(s_axis_b_tdata);
    sign1_d = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
    exp1_d  = {2'b00, s_axis_a_tdata[30:23]} + {2'b00, s_axis_b_tdata[30:23]} - 10'sd127;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF))
      cls1_d = CLS_NAN;
    else if (cls_a == CLS_INF || cls_b == CLS_INF)
      cls1_d = CLS_INF;
    else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
      cls1_d = CLS_ZERO;
    else
      cls1_d = CLS_NUM;
  end

  // Stage 2: mantissa product
  cls_e              cls2_q;
  logic              sign2_q;
  logic signed [9:0] exp2_q;
  logic [47:0]       prod2_d, prod2_q;
  logic              v2_q;

  assign prod2_d = {24'd0, mant_a1_q} * {24'd0, mant_b1_q};

  // Stage 3: normalise and extract guard/sticky
  cls_e              cls3_q;
  logic              sign3_q;
  logic signed [9:0] exp3_d, exp3_q;
  logic [23:0]       mant3_d, mant3_q;
  logic              guard3_d, guard3_q, sticky3_d, sticky3_q;
  logic              v3_q;

  always_comb begin
    if (prod2_q[47]) begin
      mant3_d   = prod2_q[47:24];
      guard3_d  = prod2_q[23];
      sticky3_d = |prod2_q[22:0];
      exp3_d    = exp2_q + 10'sd1;
    end else begin
      mant3_d   = prod2_q[46:23];
      guard3_d  = prod2_q[22];
      sticky3_d = |prod2_q[21:0];
      exp3_d    = exp2_q;
    end
  end

  // Round to nearest even, renormalise on carry-out, then pack or substitute specials
  logic              round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;
  logic [31:0]       res_d, tdata_q;
  logic              tvalid_q;

  always_comb begin
    round_up = guard3_q & (sticky3_q | mant3_q[0]);
    mant_r   = {1'b0, mant3_q} + {24'd0, round_up};
    if (mant_r[24]) begin
      frac_r = mant_r[23:1];
      exp_r  = exp3_q + 10'sd1;
    end else begin
      frac_r = mant_r[22:0];
      exp_r  = exp3_q;
    end
    res_d = {sign3_q, 31'd0};
    case (cls3_q)
      CLS_NAN:  res_d = 32'h7FC0_0000;
      CLS_INF:  res_d = {sign3_q, 8'hFF, 23'd0};
      CLS_ZERO: res_d = {sign3_q, 31'd0};
      default: begin
        if (exp_r <= 10'sd0)        res_d = {sign3_q, 31'd0};
        else if (exp_r >= 10'sd255) res_d = {sign3_q, 8'hFF, 23'd0};
        else                        res_d = {sign3_q, exp_r[7:0], frac_r};
      end
    endcase
  end

  // Datapath registers run freely; only the valid chain and visible output carry reset.
  always_ff @(posedge clk) begin
    cls1_q    <= cls1_d;
    sign1_q   <= sign1_d;
    exp1_q    <= exp1_d;
    mant_a1_q <= {1'b1, s_axis_a_tdata[22:0]};
    mant_b1_q <= {1'b1, s_axis_b_tdata[22:0]};
    cls2_q    <= cls1_q;
    sign2_q   <= sign1_q;
    exp2_q    <= exp1_q;
    prod2_q   <= prod2_d;
    cls3_q    <= cls2_q;
    sign3_q   <= sign2_q;
    exp3_q    <= exp3_d;
    mant3_q   <= mant3_d;
    guard3_q  <= guard3_d;
    sticky3_q <= sticky3_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 32'd0;
    end else begin
      v1_q     <= accept;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      tvalid_q <= v3_q;
      if (v3_q) tdata_q <= res_d;
    end
  end

`ifdef SYNTHESIJER_FMUL32_OUTREG_EN
  logic [31:0] tdata_o_q;
  logic        tvalid_o_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid_o_q <= 1'b0;
      tdata_o_q  <= 32'd0;
    end else begin
      tvalid_o_q <= tvalid_q;
      if (tvalid_q) tdata_o_q <= tdata_q;
    end
  end

  assign m_axis_result_tdata  = tdata_o_q;
  assign m_axis_result_tvalid = tvalid_o_q;
`else
  assign m_axis_result_tdata  = tdata_q;
  assign m_axis_result_tvalid = tvalid_q;
`endif
endmodule

// File: tb/tb_synthesijer_fmul32_core.sv
// Directed bench for synthesijer_fmul32_core; inputs change and outputs are sampled on the falling edge.
module tb_synthesijer_fmul32_core;
`ifdef SYNTHESIJER_FMUL32_OUTREG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid;
  logic [31:0] r_tdata;
  logic        r_tvalid;

  always #5 clk = ~clk;

  synthesijer_fmul32_core dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_b_tdata       (b_tdata),
    .s_axis_b_tvalid      (b_tvalid),
    .m_axis_result_tdata  (r_tdata),
    .m_axis_result_tvalid (r_tvalid)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] op_a_q[$];
  logic [31:0] op_b_q[$];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    op_a_q.push_back(a);
    op_b_q.push_back(b);
    exp_q.push_back(r);
  endtask

  // Drives the queued operands on consecutive cycles and checks every cycle that the
  // results appear exactly LAT cycles after acceptance, in order, and nowhere else.
  task automatic run_burst(input string tag);
    int n = op_a_q.size();
    for (int k = 0; k <= LAT + n + 1; k++) begin
      if (k > 0) begin
        if (k >= LAT + 1 && k <= LAT + n) begin
          chk1({tag, "_valid"}, r_tvalid, 1'b1);
          chk32({tag, "_data"}, r_tdata, exp_q.pop_front());
        end else begin
          chk1({tag, "_idle"}, r_tvalid, 1'b0);
        end
      end
      if (k < n) begin
        a_tdata  = op_a_q[k];
        b_tdata  = op_b_q[k];
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
      end else begin
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
      end
      @(negedge clk);
    end
    op_a_q.delete();
    op_b_q.delete();
  endtask

  task automatic idle_watch(input string tag, input int cycles, input logic [31:0] held);
    for (int k = 0; k < cycles; k++) begin
      chk1({tag, "_nopulse"}, r_tvalid, 1'b0);
      chk32({tag, "_held"}, r_tdata, held);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset with a valid pair presented: must not be accepted
    reset    = 1'b1;
    a_tdata  = 32'h4000_0000;
    b_tdata  = 32'h4040_0000;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk1("reset_tvalid", r_tvalid, 1'b0);
    chk32("reset_tdata", r_tdata, 32'h0000_0000);
    reset    = 1'b0;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    idle_watch("post_reset", LAT + 2, 32'h0000_0000);

    // Single product: 2.0 * 3.0
    push_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    run_burst("single");

    // Back-to-back: 1.5^2, 1-ulp rounding-down case, overflow
    push_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    push_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    push_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    run_burst("b2b");

    // Special operands, flush-to-zero, sign handling, round-half-up on odd lsb
    push_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    push_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    push_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
    push_op(32'h0040_0000, 32'hC000_0000, 32'h8000_0000);
    push_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    push_op(32'hFFC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    push_op(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    push_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
    run_burst("special");

    // Only one side valid: nothing accepted, last result held
    a_tdata  = 32'h4000_0000;
    b_tdata  = 32'h4000_0000;
    a_tvalid = 1'b1;
    b_tvalid = 1'b0;
    repeat (5) @(negedge clk);
    a_tvalid = 1'b0;
    b_tvalid = 1'b1;
    @(negedge clk);
    b_tvalid = 1'b0;
    idle_watch("one_side", LAT + 3, 32'h3FC0_0002);

    // Reset one cycle after the second of two accepted products
    a_tdata  = 32'h4000_0000;
    b_tdata  = 32'h4040_0000;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    @(negedge clk);
    a_tdata  = 32'h3FC0_0000;
    b_tdata  = 32'h3FC0_0000;
    @(negedge clk);
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk1("flush_in_reset_tvalid", r_tvalid, 1'b0);
    chk32("flush_in_reset_tdata", r_tdata, 32'h0000_0000);
    reset = 1'b0;
    idle_watch("flush", LAT + 4, 32'h0000_0000);

    // Pipeline still healthy after the flush
    push_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    run_burst("after_flush");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/synthesijer_fmul32_core.md
SYNTHESIJER_FMUL32_CORE -- requirements
Module: synthesijer_fmul32_core

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 s_axis_a_tdata  input  32  operand A, IEEE-754 binary32.
REQ-005 s_axis_a_tvalid  input  1  operand A valid.
REQ-006 s_axis_b_tdata  input  32  operand B, IEEE-754 binary32.
REQ-007 s_axis_b_tvalid  input  1  operand B valid.
REQ-008 m_axis_result_tdata  output  32  product A*B, binary32.
REQ-009 m_axis_result_tvalid  output  1  result valid, one-cycle pulse per product.
REQ-010 The block SHALL be a drop-in responder for the fmul32_ip port set: no tready on either side.

Function
REQ-011 A transaction SHALL be accepted in a cycle where s_axis_a_tvalid and s_axis_b_tvalid are both 1.
REQ-012 A cycle with exactly one tvalid high SHALL be ignored: nothing accepted, nothing buffered.
REQ-013 Pipeline SHALL be fully pipelined: one new transaction per cycle, no stalls, no back-pressure.
REQ-014 Latency SHALL be 3 cycles from acceptance edge to m_axis_result_tvalid=1 (default build).
REQ-015 Stage 1: unpack, flag zero/inf/NaN/denormal, sign = sA XOR sB, exponent sum eA+eB-127 in 10-bit signed.
REQ-016 Stage 2: 24x24 unsigned multiply of mantissas with hidden bit, producing a 48-bit product.
REQ-017 Stage 3: normalise by 1 bit when product[47]=1 (exponent+1), round-to-nearest-even using guard and sticky bits, renormalise on mantissa carry-out, pack.
REQ-018 Denormal inputs SHALL be treated as signed zero; denormal or underflowing results (biased exponent <=0) SHALL flush to signed zero.
REQ-019 Biased exponent >=255 after rounding SHALL yield signed infinity (0x7F800000 | sign<<31).
REQ-020 Any NaN input, or inf*0, SHALL yield canonical quiet NaN 0x7FC00000.
REQ-021 inf*finite-nonzero SHALL yield signed infinity; zero*finite SHALL yield signed zero.
REQ-022 m_axis_result_tdata SHALL hold its last value when tvalid=0; results SHALL emerge in acceptance order.

Reset
REQ-023 While reset=1, all stage-valid flags and m_axis_result_tvalid SHALL be 0 on the next edge.
REQ-024 m_axis_result_tdata SHALL reset to 0x00000000.
REQ-025 Transactions in flight when reset asserts SHALL be discarded; no tvalid pulse for them after reset.
REQ-026 Inputs presented while reset=1 SHALL NOT be accepted.

Configuration
REQ-027 Macro SYNTHESIJER_FMUL32_OUTREG_EN, when defined, SHALL add one output register stage: latency 4, identical values and ordering.
REQ-028 Without SYNTHESIJER_FMUL32_OUTREG_EN, latency SHALL be 3 per REQ-014; reset behaviour SHALL be identical in both builds.

Verification
REQ-029 A=0x40000000, B=0x40400000, both valid one cycle -> tvalid pulse exactly 3 cycles later, tdata=0x40C00000.
REQ-030 Back-to-back A=B=0x3FC00000, then 0x3F800001*0x3F800001, then 0x7F000000*0x7F000000 on consecutive cycles -> consecutive results 0x40100000, 0x3F800002, 0x7F800000.
REQ-031 0x7F800000*0x00000000 -> 0x7FC00000; 0xFF800000*0x40000000 -> 0xFF800000; 0x80000000*0x40000000 -> 0x80000000.
REQ-032 a_tvalid=1 with b_tvalid=0 for 5 cycles -> no tvalid pulse ever emitted.
REQ-033 Accept two products, assert reset one cycle after the second -> tvalid stays 0, tdata=0x00000000, no late pulse.
REQ-034 Rerun REQ-029 with SYNTHESIJER_FMUL32_OUTREG_EN defined -> same tdata, tvalid 4 cycles after acceptance.
